note_sequence_recorder: RTL

NOTE_SEQUENCE_RECORDER -- requirements
Module: note_sequence_recorder

---
 rtl/note_sequence_recorder_pkg.sv | 23 ++
 rtl/note_sequence_recorder_event_ram.sv | 31 +++
 rtl/note_sequence_recorder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/note_sequence_recorder_pkg.sv
// Shared definitions for the note sequence recorder.
//   - Operating states; the encoding is also the external 'mode' value.
//   - Event entry layout: {timestamp, key_mask}, key mask in the low bits.
//   - Key level meaning.
package note_sequence_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } rec_state_t;

  // A key_state bit at this level means the key is held.
  localparam logic KEY_HELD = 1'b1;

  // Entry layout: mask occupies [NUM_CH-1:0], timestamp sits directly above it.
  localparam int ENTRY_MASK_LSB = 0;

  function automatic int entry_ts_lsb(input int num_ch);
    return ENTRY_MASK_LSB + num_ch;
  endfunction

endpackage

// File: rtl/note_sequence_recorder_event_ram.sv
// event_ram: simple dual-port event memory, DEPTH x DW.
//   clk      : clock, rising edge
//   wr_en    : write strobe, wr_data stored at wr_addr on the clock edge
//   wr_addr  : write address
//   wr_data  : entry to store
//   rd_addr  : read address, sampled on the clock edge
//   rd_data  : registered read data (one cycle after rd_addr)
// No reset on the array or read register so the memory maps onto block RAM.
module event_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/note_sequence_recorder.sv
// note_sequence_recorder: records key-press events with millisecond-style
// timestamps and plays them back as one-cycle note pulses.
//   CLOCK_50    : sole clock, rising edge
//   resetn      : asynchronous active-low reset
//   key_state   : key levels, 1 = held
//   start_rec   : one-cycle request to start recording
//   start_play  : one-cycle request to start playback
//   stop        : one-cycle request to end recording/playback (highest priority)
//   loop_en     : level, playback repeats while 1
//   play_note   : one-cycle pulse of the stored key mask per played event
//   mode        : 00 idle, 01 record, 10 play
//   event_count : number of stored entries
//   overflow    : sticky, a rise was dropped because memory was full
module note_sequence_recorder
  import note_sequence_recorder_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DEPTH    = 64,
  parameter int TS_W     = 16,
  parameter int TICK_DIV = 50000,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] key_state,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [NUM_CH-1:0] play_note,
  output logic [1:0]        mode,
  output logic [CW-1:0]     event_count,
  output logic              overflow
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW     = TS_W + NUM_CH;
  localparam int TS_LSB = entry_ts_lsb(NUM_CH);

  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TS_W-1:0] TS_MAX     = '1;
  localparam logic [CW-1:0]   COUNT_FULL = CW'(DEPTH);

  rec_state_t        state_reg, state_next;
  logic [PW-1:0]     presc_reg, presc_next;
  // One timer serves as the record timestamp and as the play timer;
  // the two are never needed at the same time.
  logic [TS_W-1:0]   time_reg, time_next;
  logic [NUM_CH-1:0] hist_reg, hist_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic [CW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [NUM_CH-1:0] play_note_reg, play_note_next;

  logic [NUM_CH-1:0] rise;
  logic              tick;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [EW-1:0]     wr_data;
  logic [EW-1:0]     rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic [NUM_CH-1:0] rd_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rise
      assign rise[gi] = (key_state[gi] == KEY_HELD) && (hist_reg[gi] != KEY_HELD);
    end
  endgenerate

  assign tick    = (presc_reg == PRESC_LAST);
  assign rd_ts   = rd_data[TS_LSB +: TS_W];
  assign rd_mask = rd_data[ENTRY_MASK_LSB +: NUM_CH];

  // The read address follows rd_ptr_next so that rd_data always holds the
  // entry addressed by rd_ptr_reg; a match therefore pulses one cycle later
  // and back-to-back entries with equal timestamps play on consecutive cycles.
  event_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (EW)
  ) u_event_ram (
    .clk     (CLOCK_50),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_next[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    time_next      = time_reg;
    hist_next      = hist_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    rd_ptr_next    = rd_ptr_reg;
    play_note_next = '0;
    wr_en          = 1'b0;
    wr_addr        = count_reg[AW-1:0];
    wr_data        = {time_reg, rise};

    case (state_reg)
      ST_IDLE: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (start_rec) begin
          state_next    = ST_RECORD;
          count_next    = '0;
          overflow_next = 1'b0;
          time_next     = '0;
          presc_next    = '0;
          hist_next     = key_state;
        end else if (start_play && (count_reg != '0)) begin
          state_next  = ST_PLAY;
          time_next   = '0;
          presc_next  = '0;
          rd_ptr_next = '0;
        end
      end

      ST_RECORD: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else begin
          hist_next  = key_state;
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (tick) begin
            if (time_reg == TS_MAX) begin
              state_next = ST_IDLE;
            end else begin
              time_next = time_reg + 1'b1;
            end
          end
          if (rise != '0) begin
            if (count_reg == COUNT_FULL) begin
              overflow_next = 1'b1;
            end else begin
              wr_en      = 1'b1;
              count_next = count_reg + 1'b1;
            end
          end
        end
      end

      ST_PLAY: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (rd_ptr_reg == count_reg) begin
          if (loop_en) begin
            time_next   = '0;
            presc_next  = '0;
            rd_ptr_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (tick && (time_reg != TS_MAX)) begin
            time_next = time_reg + 1'b1;
          end
          if (time_reg == rd_ts) begin
            play_note_next = rd_mask;
            rd_ptr_next    = rd_ptr_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      presc_reg     <= '0;
      time_reg      <= '0;
      hist_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      rd_ptr_reg    <= '0;
      play_note_reg <= '0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      time_reg      <= time_next;
      hist_reg      <= hist_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      rd_ptr_reg    <= rd_ptr_next;
      play_note_reg <= play_note_next;
    end
  end

  assign play_note   = play_note_reg;
  assign mode        = state_reg;
  assign event_count = count_reg;
  assign overflow    = overflow_reg;

endmodule
